line_burst_adaptor: RTL and testbench

Converts the 256-bit single-transfer cache-line memory port of the `mp3` top (driven by the L2 cache) into a 4-beat, 64-bit burst interface toward physical memory/DRAM. It sits directly downstream of `mp3`: its line side connects to `mp3`'s `read`/`write`/`address`/`wdata`/`rdata`/`resp`, and its burst side connects to the memory model. It latches one line request, serializes or deserializes the data over four beats, and returns a single-cycle line response.

---
 rtl/burst_pkg.sv | 21 ++
 rtl/line_beat_buffer.sv | 33 +++
 rtl/line_burst_adaptor.sv | 104 ++++++++++
 tb/tb_line_burst_adaptor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared constants, state encoding and address helper for the line-to-burst adaptor.
package burst_pkg;
  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clear the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~{{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};
  endfunction
endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load for writes, per-beat fill for reads,
// and a beat-select mux for serialising write data.
module line_beat_buffer
  import burst_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_W-1:0]  load_data,
  input  logic               beat_we,
  input  logic [CNT_W-1:0]   beat_idx,
  input  logic [BURST_W-1:0] beat_data,
  input  logic [CNT_W-1:0]   rd_idx,
  output logic [BURST_W-1:0] rd_beat,
  output logic [LINE_W-1:0]  line
);

  logic [LINE_W-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (beat_we) begin
      data[int'(beat_idx)*BURST_W +: BURST_W] <= beat_data;
    end
  end

  assign rd_beat = data[int'(rd_idx)*BURST_W +: BURST_W];
  assign line    = data;

endmodule

// File: rtl/line_burst_adaptor.sv
// Bridges a single-transfer 256-bit line port to a 4-beat 64-bit memory burst port.
// Holds the request FSM, beat counter and line-aligned address register.
module line_burst_adaptor
  import burst_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [ADDR_W-1:0]  line_address,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [ADDR_W-1:0]  burst_addr_o,
  output logic [BURST_W-1:0] burst_wdata_o,
  input  logic [BURST_W-1:0] burst_rdata_i,
  input  logic               burst_resp_i
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              buf_load;
  logic              buf_beat_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      addr          <= '0;
      line_resp     <= 1'b0;
      burst_read_o  <= 1'b0;
      burst_write_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          line_resp <= 1'b0;
          // A write takes priority when both requests arrive together.
          if (line_write) begin
            addr          <= line_align(line_address);
            cnt           <= '0;
            burst_write_o <= 1'b1;
            state         <= WRITE;
          end else if (line_read) begin
            addr         <= line_align(line_address);
            cnt          <= '0;
            burst_read_o <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          if (burst_resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              burst_read_o <= 1'b0;
              line_resp    <= 1'b1;
              state        <= DONE;
            end
          end
        end
        WRITE: begin
          if (burst_resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              burst_write_o <= 1'b0;
              line_resp     <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          line_resp <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign buf_load    = (state == IDLE) && line_write;
  assign buf_beat_we = (state == READ) && burst_resp_i;

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (line_wdata),
    .beat_we   (buf_beat_we),
    .beat_idx  (cnt),
    .beat_data (burst_rdata_i),
    .rd_idx    (cnt),
    .rd_beat   (burst_wdata_o),
    .line      (line_rdata)
  );

  assign burst_addr_o = addr;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Testbench for line_burst_adaptor: vector table, directed corner sequences and
// randomized transactions checked against a line-level memory model.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [31:0]  burst_addr_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;

  int checks = 0;
  int passes = 0;
  logic [31:0] last_addr;

  line_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_addr_o  (burst_addr_o),
    .burst_wdata_o (burst_wdata_o),
    .burst_rdata_i (burst_rdata_i),
    .burst_resp_i  (burst_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_align(input logic [31:0] a);
    return (a / 32) * 32;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One line transaction, entered and left at a negedge.
  // mode 0: back-to-back beats, 1: handshake pattern bits (LSB first, then 1s), 2: random gaps.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [255:0] wd, input logic [255:0] mem,
                     input logic [31:0] exp_addr, input bit exp_wr,
                     input int mode, input logic [15:0] pat, input bit chk_lat);
    logic [255:0] exp_line;
    int k, cyc, pi;
    bit r;
    k = 0; cyc = 1; pi = 0;
    exp_line = exp_wr ? wd : mem;
    line_write = wr; line_read = rd; line_address = a; line_wdata = wd;
    burst_resp_i = 1'b0;
    @(posedge clk); cyc++;
    @(negedge clk);
    while (k < 4 && cyc < 300) begin
      check("burst_read", burst_read_o, !exp_wr);
      check("burst_write", burst_write_o, exp_wr);
      check("burst_addr", burst_addr_o, exp_addr);
      check("resp_mid", line_resp, 0);
      if (exp_wr) check("wbeat", burst_wdata_o, wd[64*k +: 64]);
      line_address = $urandom;
      line_wdata = rand_line();
      case (mode)
        0: r = 1'b1;
        1: r = (pi < 16) ? pat[pi] : 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      pi++;
      burst_resp_i = r;
      burst_rdata_i = r ? mem[64*k +: 64] : {$urandom, $urandom};
      @(posedge clk); cyc++;
      if (r) k++;
      @(negedge clk);
    end
    burst_resp_i = 1'b0;
    if (k < 4) check("burst_timeout", 256'(k), 256'(4));
    check("resp_pulse", line_resp, 1);
    check("rd_drop", burst_read_o, 0);
    check("wr_drop", burst_write_o, 0);
    check("line_rdata", line_rdata, exp_line);
    if (chk_lat) check("latency", 256'(cyc), 256'(6));
    line_read = 1'b0; line_write = 1'b0;
    @(negedge clk);
    check("resp_single", line_resp, 0);
    check("rdata_held", line_rdata, exp_line);
    check("addr_held", burst_addr_o, exp_addr);
    last_addr = exp_addr;
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    bit          exp_wr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [255:0] wd, mem;
    logic [31:0] a;
    bit wr, rd;
    int idle;

    vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1234, exp_addr: 32'h0000_1220, exp_wr: 1'b0};
    vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0040, exp_addr: 32'h0000_0040, exp_wr: 1'b1};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_wr: 1'b1};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0, exp_wr: 1'b0};
    vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_001F, exp_addr: 32'h0000_0000, exp_wr: 1'b1};
    vecs[5] = '{wr: 1'b0, rd: 1'b1, addr: 32'h8000_0020, exp_addr: 32'h8000_0020, exp_wr: 1'b0};

    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata_i = '0; burst_resp_i = 1'b0;
    #1;
    check("rst_resp", line_resp, 0);
    check("rst_rd", burst_read_o, 0);
    check("rst_wr", burst_write_o, 0);
    check("rst_addr", burst_addr_o, 0);
    check("rst_wdata", burst_wdata_o, 0);
    check("rst_rdata", line_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_addr = '0;

    // Read with back-to-back beats 0x11.., 0x22.., 0x33.., 0x44..
    mem = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    txn(0, 1, 32'h0000_1234, '0, mem, 32'h0000_1220, 0, 0, 16'h0, 1);

    // Write with handshake gaps 1,0,0,1,1,0,1
    wd = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    txn(1, 0, 32'h0000_0040, wd, rand_line(), 32'h0000_0040, 1, 1, 16'h0059, 0);

    // Table of request kinds and alignment corners
    foreach (vecs[i]) begin
      wd = rand_line(); mem = rand_line();
      txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, wd, mem, vecs[i].exp_addr, vecs[i].exp_wr,
          0, 16'h0, 1);
    end

    // Stray handshakes while idle
    burst_resp_i = 1'b1; burst_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("stray_resp", line_resp, 0);
      check("stray_rd", burst_read_o, 0);
      check("stray_wr", burst_write_o, 0);
      check("stray_addr", burst_addr_o, last_addr);
    end
    burst_resp_i = 1'b0;

    // Reset in the middle of a read after two beats
    line_read = 1'b1; line_address = 32'h0000_0300;
    @(posedge clk); @(negedge clk);
    repeat (2) begin
      burst_resp_i = 1'b1; burst_rdata_i = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("mrst_rd", burst_read_o, 0);
    check("mrst_resp", line_resp, 0);
    check("mrst_addr", burst_addr_o, 0);
    check("mrst_wdata", burst_wdata_o, 0);
    check("mrst_rdata", line_rdata, 0);
    line_read = 1'b0; burst_resp_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("mrst_noresp", line_resp, 0);
      check("mrst_idle", burst_read_o, 0);
    end
    txn(0, 1, 32'h0000_0200, '0, rand_line(), 32'h0000_0200, 0, 0, 16'h0, 1);

    // Back-to-back reads: second request one cycle after line_resp
    txn(0, 1, 32'h0000_1000, '0, rand_line(), 32'h0000_1000, 0, 0, 16'h0, 1);
    txn(0, 1, 32'h0000_2008, '0, rand_line(), 32'h0000_2000, 0, 0, 16'h0, 1);

    // Randomized transactions with random beat gaps and idle stray handshakes
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom; wd = rand_line(); mem = rand_line();
      txn(wr, rd, a, wd, mem, model_align(a), wr, 2, 16'h0, 0);
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        burst_resp_i = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        check("rand_idle_resp", line_resp, 0);
      end
      burst_resp_i = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
